// File: rtl/tappy_pkg.sv
// Shared types and byte constants for the PS/2 scancode decoder.
package tappy_pkg;

  // Decoder prefix states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } dec_state_t;

  // One decoded key event as held in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } scan_event_t;

  // Protocol bytes with special meaning.
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FC = 8'hFC;
  localparam logic [7:0] BYTE_00 = 8'h00;

  // Bytes that follow E1 in the Pause sequence before the event is emitted.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Error bytes abort any sequence regardless of state.
  function automatic logic is_abort_byte(input logic [7:0] b);
    return (b == BYTE_FC) || (b == BYTE_00);
  endfunction

endpackage

// File: rtl/scan_fifo.sv
// Small event FIFO: write on push, show head combinationally while non-empty.
module scan_fifo
  import tappy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  scan_event_t push_ev,
  input  logic        pop_ready,
  output logic        valid,
  output scan_event_t head,
  output logic        drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full, do_pop, do_push;

  scan_event_t mem [DEPTH];

  // Occupancy flags and accepted push/pop; a pop frees the slot a full push needs.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = !empty && pop_ready;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  // Pointer advance with natural wrap of the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_ev;
  end

  // Head is forced to zero when empty so outputs are quiet in and after reset.
  always_comb begin
    valid = !empty;
    head  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/scan_decoder.sv
// PS/2 scancode decoder: prefix FSM, inter-byte timeout and event FIFO.
module scan_decoder
  import tappy_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] word,
  input  logic       done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       bat_ok,
  output logic       err,
  output logic       overflow
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  dec_state_t  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic        bat_ok_q, bat_ok_d;
  logic        err_q, err_d;
  logic        overflow_q, overflow_d;

  logic        abort_byte;
  logic        tmo_expire;
  logic        push;
  scan_event_t push_ev;
  scan_event_t head_ev;
  logic        fifo_drop;

  // Expiry only counts when no byte arrives; a byte in that cycle wins.
  always_comb begin
    abort_byte = done && is_abort_byte(word);
    tmo_expire = (state_q != ST_IDLE) && !done &&
                 (tmo_q == TMO_W'(TIMEOUT - 1));
  end

  // State, counter and pulse registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      bat_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      bat_ok_q   <= bat_ok_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state: prefix tracking, E1 restarts a Pause sequence outside PAUSE.
  always_comb begin
    state_d = state_q;
    if (done) begin
      if (abort_byte) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (word == BYTE_E0)      state_d = ST_EXT;
            else if (word == BYTE_F0) state_d = ST_BRK;
            else if (word == BYTE_E1) state_d = ST_PAUSE;
            else                      state_d = ST_IDLE;
          end
          ST_EXT: begin
            if (word == BYTE_F0)      state_d = ST_EXT_BRK;
            else if (word == BYTE_E0) state_d = ST_EXT;
            else if (word == BYTE_E1) state_d = ST_PAUSE;
            else                      state_d = ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: begin
            if (word == BYTE_E1)      state_d = ST_PAUSE;
            else                      state_d = ST_IDLE;
          end
          ST_PAUSE: begin
            if (skip_q <= 3'd1)       state_d = ST_IDLE;
          end
          default:                    state_d = ST_IDLE;
        endcase
      end
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end
  end

  // Skip and timeout counters; every byte restarts the inter-byte timer.
  always_comb begin
    skip_d = skip_q;
    tmo_d  = '0;
    if (done) begin
      if (abort_byte)                                  skip_d = '0;
      else if (state_q == ST_PAUSE)                    skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
      else if (word == BYTE_E1)                        skip_d = PAUSE_SKIP;
    end else if (tmo_expire) begin
      skip_d = '0;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Outputs: event pushes and the one-cycle status pulses.
  always_comb begin
    push       = 1'b0;
    push_ev    = '0;
    bat_ok_d   = 1'b0;
    err_d      = tmo_expire;
    overflow_d = fifo_drop;
    if (done) begin
      if (abort_byte) begin
        err_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (word == BYTE_AA) begin
              bat_ok_d = 1'b1;
            end else if (word != BYTE_E0 && word != BYTE_F0 && word != BYTE_E1) begin
              push    = 1'b1;
              push_ev = '{code: word, ext: 1'b0, brk: 1'b0};
            end
          end
          ST_EXT: begin
            if (word != BYTE_E0 && word != BYTE_F0 && word != BYTE_E1) begin
              push    = 1'b1;
              push_ev = '{code: word, ext: 1'b1, brk: 1'b0};
            end
          end
          ST_BRK: begin
            if (word != BYTE_E1) begin
              push    = 1'b1;
              push_ev = '{code: word, ext: 1'b0, brk: 1'b1};
            end
          end
          ST_EXT_BRK: begin
            if (word != BYTE_E1) begin
              push    = 1'b1;
              push_ev = '{code: word, ext: 1'b1, brk: 1'b1};
            end
          end
          ST_PAUSE: begin
            if (skip_q <= 3'd1) begin
              push    = 1'b1;
              push_ev = '{code: BYTE_E1, ext: 1'b1, brk: 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  scan_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (sysclk),
    .rst_n    (reset),
    .push     (push),
    .push_ev  (push_ev),
    .pop_ready(ev_ready),
    .valid    (ev_valid),
    .head     (head_ev),
    .drop     (fifo_drop)
  );

  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;
  assign bat_ok   = bat_ok_q;
  assign err      = err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Randomized and directed bench for scan_decoder against a prefix-set model.
module tb_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 24;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] word = 8'h00;
  logic       done = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_break, bat_ok, err, overflow;
  logic [7:0] ev_code;

  always #5 sysclk = ~sysclk;

  scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .word    (word),
    .done    (done),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_code (ev_code),
    .ev_ext  (ev_ext),
    .ev_break(ev_break),
    .bat_ok  (bat_ok),
    .err     (err),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queued events {code,ext,brk}, prefix seen, pause bytes left, idle cycles.
  logic [9:0] m_q[$];
  bit         m_e0, m_f0;
  int         m_pause, m_idle;
  bit         m_err, m_bat, m_ovf;

  // Observations from the DUT.
  logic [9:0] got[$];
  int         o_err, o_bat, o_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_e0 = 0; m_f0 = 0; m_pause = 0; m_idle = 0;
    m_err = 0; m_bat = 0; m_ovf = 0;
  endtask

  task automatic clear_obs();
    got.delete();
    o_err = 0; o_bat = 0; o_ovf = 0;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model.
  task automatic step(input bit d, input logic [7:0] w, input bit r);
    bit         do_push;
    logic [9:0] pev;
    @(negedge sysclk);
    check("ev_valid", ev_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("ev_head", {ev_code, ev_ext, ev_break}, m_q[0]);
    check("bat_ok", bat_ok, m_bat);
    check("err", err, m_err);
    check("overflow", overflow, m_ovf);
    o_err += int'(err); o_bat += int'(bat_ok); o_ovf += int'(overflow);
    done = d; word = w; ev_ready = r;
    if (r && ev_valid) begin
      got.push_back({ev_code, ev_ext, ev_break});
      $display("pop code=%02h ext=%0d brk=%0d", ev_code, ev_ext, ev_break);
    end
    m_err = 0; m_bat = 0; m_ovf = 0; do_push = 0; pev = '0;
    if (d) begin
      m_idle = 0;
      if (w == 8'hFC || w == 8'h00) begin
        m_err = 1; m_e0 = 0; m_f0 = 0; m_pause = 0;
      end else if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin do_push = 1; pev = {8'hE1, 2'b10}; end
      end else if (w == 8'hE1) begin
        m_pause = 7; m_e0 = 0; m_f0 = 0;
      end else if (!m_e0 && !m_f0 && w == 8'hAA) begin
        m_bat = 1;
      end else if (w == 8'hE0 && !m_f0) begin
        m_e0 = 1;
      end else if (w == 8'hF0 && !m_f0) begin
        m_f0 = 1;
      end else begin
        do_push = 1; pev = {w, m_e0, m_f0}; m_e0 = 0; m_f0 = 0;
      end
    end else if (m_e0 || m_f0 || m_pause > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1; m_e0 = 0; m_f0 = 0; m_pause = 0; m_idle = 0;
      end
    end
    if (r && m_q.size() != 0) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pev);
      else m_ovf = 1;
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 8'h00, r);
  endtask

  task automatic send(input logic [7:0] w, input bit r);
    step(1, w, r);
    step(0, 8'h00, r);
  endtask

  // Asynchronous reset assertion mid-cycle, checked while held.
  task automatic do_reset();
    @(negedge sysclk);
    #2;
    reset = 1'b0; done = 1'b0; ev_ready = 1'b0;
    #1;
    check("rst_async_valid", ev_valid, 0);
    @(posedge sysclk); #1;
    check("rst_valid", ev_valid, 0);
    check("rst_head", {ev_code, ev_ext, ev_break}, 0);
    check("rst_pulses", {bat_ok, err, overflow}, 0);
    @(negedge sysclk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    int pick;
    logic [7:0] b;
    model_clear();
    clear_obs();
    do_reset();

    // Make then break of one key.
    clear_obs();
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); idle(3, 1);
    check("s1_count", got.size(), 2);
    if (got.size() == 2) begin
      check("s1_ev0", got[0], {8'h1C, 2'b00});
      check("s1_ev1", got[1], {8'h1C, 2'b01});
    end

    // Extended make and break.
    clear_obs();
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(3, 1);
    check("s2_count", got.size(), 2);
    if (got.size() == 2) begin
      check("s2_ev0", got[0], {8'h75, 2'b10});
      check("s2_ev1", got[1], {8'h75, 2'b11});
    end

    // Pause key sequence yields a single event.
    clear_obs();
    send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
    send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 1); idle(3, 1);
    check("s3_count", got.size(), 1);
    if (got.size() == 1) check("s3_ev0", got[0], {8'hE1, 2'b10});

    // Overflow, then simultaneous pop and push on a full FIFO.
    clear_obs();
    for (int i = 0; i < 5; i++) step(1, 8'h15 + 8'(i), 0);
    idle(2, 0);
    check("s4_ovf_count", o_ovf, 1);
    check("s4_full_valid", ev_valid, 1);
    step(1, 8'h1A, 1);
    idle(8, 1);
    check("s4_ovf_after", o_ovf, 1);
    check("s4_count", got.size(), 5);
    if (got.size() == 5) begin
      check("s4_ev0", got[0], {8'h15, 2'b00});
      check("s4_ev3", got[3], {8'h18, 2'b00});
      check("s4_ev4", got[4], {8'h1A, 2'b00});
    end

    // Timeout after a lone break prefix.
    clear_obs();
    step(1, 8'hF0, 1);
    idle(TMO + 3, 1);
    check("s5_err_count", o_err, 1);
    send(8'h1C, 1); idle(2, 1);
    check("s5_count", got.size(), 1);
    if (got.size() == 1) check("s5_ev0", got[0], {8'h1C, 2'b00});

    // BAT and error bytes, then reset in the middle of a prefix.
    clear_obs();
    send(8'hAA, 1); send(8'hFC, 1); idle(2, 1);
    check("s6_bat", o_bat, 1);
    check("s6_err", o_err, 1);
    check("s6_none", got.size(), 0);
    send(8'hE0, 1);
    do_reset();
    clear_obs();
    send(8'h1C, 1); idle(2, 1);
    check("s6_count", got.size(), 1);
    if (got.size() == 1) check("s6_ev0", got[0], {8'h1C, 2'b00});

    // Randomized byte streams with gaps, back-pressure and occasional reset.
    for (int n = 0; n < 2500; n++) begin
      pick = int'($urandom_range(0, 19));
      case (pick)
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(1, 8'h7F));
        6, 7:   b = 8'hE0;
        8, 9:   b = 8'hF0;
        10:     b = 8'hE1;
        11:     b = 8'hAA;
        12:     b = ($urandom_range(0, 1) == 0) ? 8'hFC : 8'h00;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) idle(TMO + 2, $urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 999) == 0) do_reset();
      else step($urandom_range(0, 1) == 1, b, $urandom_range(0, 9) < 6);
    end
    idle(DEPTH + 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 2000, sysclk cycles a prefix state may wait for its next byte.
REQ-003 SHALL have port sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port word  input  8  received PS/2 byte from the upstream receiver.
REQ-006 SHALL have port done  input  1  one-cycle strobe; word is valid in that cycle.
REQ-007 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-009 SHALL have port ev_code  output  8  key scancode of the head event.
REQ-010 SHALL have port ev_ext  output  1  head event was E0- or E1-prefixed.
REQ-011 SHALL have port ev_break  output  1  head event is a key release.
REQ-012 SHALL have port bat_ok  output  1  one-cycle pulse on received byte 8'hAA while in IDLE.
REQ-013 SHALL have port err  output  1  one-cycle pulse on byte 8'hFC or 8'h00 in any state, or on a timeout.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-015 SHALL decode with states IDLE, EXT, BRK, EXT_BRK, PAUSE; bytes are consumed only in cycles with done=1.
REQ-016 IDLE: E0->EXT; F0->BRK; E1->PAUSE with skip counter 7; AA->bat_ok, stay IDLE; FC/00->err, stay IDLE; any other byte->push {code,ext=0,brk=0}.
REQ-017 EXT: F0->EXT_BRK; E0 stays EXT; other byte->push {code,1,0}, go IDLE.
REQ-018 BRK: other byte->push {code,0,1}, go IDLE; EXT_BRK: other byte->push {code,1,1}, go IDLE.
REQ-019 PAUSE: discard each byte, decrement counter; on the byte that reaches 0, push {8'hE1,1,0} and go IDLE.
REQ-020 FC or 00 in any state SHALL pulse err and force IDLE, with no push; E1 received outside IDLE SHALL abandon the prefix and enter PAUSE.
REQ-021 SHALL reload the timeout counter on every done, count while in a non-IDLE state, and on reaching TIMEOUT pulse err and return to IDLE; if done coincides with expiry, the byte is processed and no err is raised.
REQ-022 A push SHALL write the FIFO on the edge ending the done cycle; ev_valid SHALL therefore rise the cycle after done when the FIFO was empty.
REQ-023 Pop SHALL occur on any edge with ev_valid=1 and ev_ready=1; ev_code/ev_ext/ev_break SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-024 Push when full SHALL drop the new event and pulse overflow, unless a pop occurs in the same cycle, in which case the push succeeds.
REQ-025 Push and pop on an empty FIFO in the same cycle SHALL NOT bypass; the pushed event appears next cycle.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide with natural wrap; full = MSBs differ and the remaining bits are equal.

Reset
REQ-027 While reset=0, the block SHALL be in state IDLE, have an empty FIFO, have timeout and skip counters at 0, and drive ev_valid, ev_code, ev_ext, ev_break, bat_ok, err and overflow to 0.
REQ-028 Reset asserted mid-sequence SHALL discard any partial prefix and all queued events.

Structure
REQ-029 The shared package tappy_pkg SHALL hold the state enum, the event struct {code, ext, brk}, and the byte constants E0, F0, E1, AA, FC and 00.
REQ-030 The event FIFO SHALL be a separate sub-module, scan_fifo, parameterised by depth and carrying the event struct; the decoder FSM and timeout logic SHALL reside in scan_decoder.

Verification
REQ-031 Scenario 1: bytes 1C, F0, 1C with ev_ready=1 -> events {1C,0,0} then {1C,0,1}.
REQ-032 Scenario 2: bytes E0, 75, E0, F0, 75 -> events {75,1,0} then {75,1,1}.
REQ-033 Scenario 3: bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}, no other event.
REQ-034 Scenario 4: with ev_ready=0, push 5 make codes at FIFO_DEPTH=4 -> 4 events retained in order, 1 overflow pulse; raise ev_ready and push in the same cycle on the full FIFO -> no overflow.
REQ-035 Scenario 5: byte F0, then no byte for TIMEOUT cycles -> err pulse, state IDLE; next byte 1C -> {1C,0,0}.
REQ-036 Scenario 6: bytes AA then FC -> bat_ok pulse, then err pulse, no events; reset asserted after E0 -> next 1C yields {1C,0,0}.
